// File: rtl/input_injector_if.sv
// Host command channel into the input injector: one valid/ready transfer per command.
// Latency: n/a (signal bundle only).
// Backpressure: host holds cmd_valid/cmd_ch/cmd_op stable until it sees cmd_ready on the same cycle.
//
// Signals:
//   cmd_valid  host -> injector  command present
//   cmd_ready  injector -> host  command can be taken this cycle
//   cmd_ch     host -> injector  target channel index
//   cmd_op     host -> injector  00 lever off, 01 lever on, 10 lever toggle, 11 button press
interface input_injector_if #(
    parameter int CH_W = 4
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    logic [1:0]      cmd_op;

    modport master (output cmd_valid, output cmd_ch, output cmd_op, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_op, output cmd_ready);
endinterface

// File: rtl/input_injector.sv
// Per-channel lever/button stimulus for the component network, committed in lock-step with i_tick.
// Latency: command staged on accept, visible on o_out the cycle after the next tick edge.
// Backpressure: cmd_ready drops on tick cycles (and in reset); host holds the command until taken.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_tick          one-cycle tick strobe; staged state commits on this cycle
//   cmd_if          host command channel (slave side)
//   o_out           registered drive to component inputs: lever | button active
//   o_btn_busy      per-channel button countdown nonzero
//   o_err           one-cycle pulse after an accepted command with channel >= CHANNELS
module input_injector #(
    parameter int CHANNELS     = 16,
    parameter int BUTTON_TICKS = 10,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input_injector_if.slave     cmd_if,
    output logic [CHANNELS-1:0] o_out,
    output logic [CHANNELS-1:0] o_btn_busy,
    output logic                o_err
);
    // Sized to hold BUTTON_TICKS exactly so the countdown can neither wrap nor underflow.
    localparam int             CNT_W    = $clog2(BUTTON_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUTTON_TICKS);

    logic [CHANNELS-1:0] lev_q,   lev_d;     // committed lever state
    logic [CHANNELS-1:0] lev_s_q, lev_s_d;   // staged lever state, edited by host commands
    logic [CHANNELS-1:0] pend_q,  pend_d;    // button press waiting for the next tick
    logic [CHANNELS-1:0] out_q,   out_d;
    logic                err_q,   err_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    logic cmd_acc;
    logic ch_ok;

    // Ready is a pure function of the tick strobe so the host never races a commit.
    assign cmd_if.cmd_ready = i_rst_n & ~i_tick;
    assign cmd_acc          = cmd_if.cmd_valid & cmd_if.cmd_ready;
    assign ch_ok            = int'(cmd_if.cmd_ch) < CHANNELS;

    always_comb begin
        lev_d   = lev_q;
        lev_s_d = lev_s_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = 1'b0;

        if (i_tick) begin
            for (int n = 0; n < CHANNELS; n++) begin
                lev_d[n] = lev_s_q[n];
                // A press during an active countdown is dropped, never restarts it.
                if (pend_q[n] && (cnt_q[n] == '0)) begin
                    cnt_d[n] = CNT_LOAD;
                end else if (cnt_q[n] != '0) begin
                    cnt_d[n] = cnt_q[n] - CNT_W'(1);
                end
                pend_d[n] = 1'b0;
                out_d[n]  = lev_s_q[n] | (cnt_d[n] != '0);
            end
        end else if (cmd_acc) begin
            if (!ch_ok) begin
                err_d = 1'b1;
            end else begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (cmd_if.cmd_ch == CH_W'(n)) begin
                        // Toggle works on the staged copy so ops between ticks compose in order.
                        case (cmd_if.cmd_op)
                            2'b00:   lev_s_d[n] = 1'b0;
                            2'b01:   lev_s_d[n] = 1'b1;
                            2'b10:   lev_s_d[n] = ~lev_s_q[n];
                            default: pend_d[n]  = 1'b1;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lev_q   <= '0;
            lev_s_q <= '0;
            pend_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            lev_q   <= lev_d;
            lev_s_q <= lev_s_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            err_q   <= err_d;
            for (int n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Derived from the registered counts, so it also only moves on tick edges.
    always_comb begin
        o_btn_busy = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            o_btn_busy[n] = (cnt_q[n] != '0);
        end
    end

    assign o_out = out_q;
    assign o_err = err_q;
endmodule

// File: tb/tb_input_injector.sv
module tb_input_injector;
    localparam int CH  = 16;
    localparam int BT  = 10;
    localparam int CHW = 5;   // one spare bit so out-of-range channels can be driven

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic [CH-1:0] out;
    logic [CH-1:0] busy;
    logic          err;

    always #5 clk = ~clk;

    input_injector_if #(.CH_W(CHW)) cmd_if ();

    input_injector #(
        .CHANNELS    (CH),
        .BUTTON_TICKS(BT),
        .CH_W        (CHW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tick    (tick),
        .cmd_if    (cmd_if),
        .o_out     (out),
        .o_btn_busy(busy),
        .o_err     (err)
    );

    typedef struct {
        logic [CH-1:0] o;
        logic [CH-1:0] b;
    } exp_t;

    typedef struct {
        bit            has_cmd;
        logic [4:0]    ch;
        logic [1:0]    op;
        bit            do_tick;
        logic [CH-1:0] exp_out;
    } vec_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad   = 0;
    int            hi0   = 0;
    logic [CH-1:0] last_out = '0;

    // Behavioural reference of the channel state.
    bit lev_s_m [CH];
    bit pend_m  [CH];
    int cnt_m   [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < CH; n++) begin
            lev_s_m[n] = 1'b0;
            pend_m[n]  = 1'b0;
            cnt_m[n]   = 0;
        end
    endfunction

    function automatic void model_cmd(input logic [4:0] ch, input logic [1:0] op);
        if (int'(ch) < CH) begin
            case (op)
                2'b00:   lev_s_m[ch] = 1'b0;
                2'b01:   lev_s_m[ch] = 1'b1;
                2'b10:   lev_s_m[ch] = ~lev_s_m[ch];
                default: pend_m[ch]  = 1'b1;
            endcase
        end
    endfunction

    function automatic exp_t model_tick();
        exp_t e;
        e.o = '0;
        e.b = '0;
        for (int n = 0; n < CH; n++) begin
            if (pend_m[n] && cnt_m[n] == 0) cnt_m[n] = BT;
            else if (cnt_m[n] != 0)         cnt_m[n] = cnt_m[n] - 1;
            pend_m[n] = 1'b0;
            e.o[n] = lev_s_m[n] | (cnt_m[n] != 0);
            e.b[n] = (cnt_m[n] != 0);
        end
        return e;
    endfunction

    task automatic send(input logic [4:0] ch, input logic [1:0] op);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = ch;
        cmd_if.cmd_op    = op;
        #1 chk("ready_idle", cmd_if.cmd_ready, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        model_cmd(ch, op);
        chk("err_pulse", err, (int'(ch) >= CH));
        chk("out_stable", out, last_out);
        @(negedge clk);
        chk("err_clear", err, 0);
    endtask

    // Hold i_tick for n consecutive cycles, scoring o_out/o_btn_busy after each commit.
    task automatic tick_n(input int n, input bit use_tbl, input logic [CH-1:0] t_out);
        exp_t e;
        @(negedge clk);
        tick = 1'b1;
        e = model_tick();
        if (use_tbl) begin
            e.o = t_out;
            e.b = '0;
        end
        sbq.push_back(e);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got no entry expected one");
            end else begin
                e = sbq.pop_front();
                chk("tick_out", out, e.o);
                chk("tick_busy", busy, e.b);
                last_out = e.o;
            end
            if (out[0]) hi0++;
            if (i < n) begin
                sbq.push_back(model_tick());
            end else begin
                tick = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [13];
        exp_t e;

        tbl[0]  = '{1'b1, 5'd3,  2'b01, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 5'd0,  2'b00, 1'b1, 16'h0008};
        tbl[2]  = '{1'b1, 5'd5,  2'b01, 1'b0, 16'h0008};
        tbl[3]  = '{1'b1, 5'd5,  2'b10, 1'b0, 16'h0008};
        tbl[4]  = '{1'b1, 5'd5,  2'b10, 1'b1, 16'h0028};
        tbl[5]  = '{1'b1, 5'd5,  2'b10, 1'b1, 16'h0008};
        tbl[6]  = '{1'b1, 5'd3,  2'b10, 1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 5'd15, 2'b01, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 5'd15, 2'b10, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 5'd15, 2'b10, 1'b1, 16'h8000};
        tbl[10] = '{1'b1, 5'd0,  2'b01, 1'b1, 16'h8001};
        tbl[11] = '{1'b1, 5'd15, 2'b00, 1'b0, 16'h8001};
        tbl[12] = '{1'b1, 5'd0,  2'b00, 1'b1, 16'h0000};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = '0;
        cmd_if.cmd_op    = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_if.cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", cmd_if.cmd_ready, 1);

        // Lever vectors
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].has_cmd) send(tbl[i].ch, tbl[i].op);
            if (tbl[i].do_tick) tick_n(1, 1'b1, tbl[i].exp_out);
            else                chk("tbl_hold", out, tbl[i].exp_out);
        end

        // Button pulse across back-to-back ticks
        hi0 = 0;
        send(5'd0, 2'b11);
        tick_n(12, 1'b0, '0);
        chk("btn_high_ticks", hi0, BT);
        chk("btn_low_end", out[0], 0);

        // Re-press mid-countdown does not extend the pulse
        hi0 = 0;
        send(5'd0, 2'b11);
        repeat (4) tick_n(1, 1'b0, '0);
        send(5'd0, 2'b11);
        repeat (8) tick_n(1, 1'b0, '0);
        chk("repress_high_ticks", hi0, BT);
        chk("repress_busy_end", busy[0], 0);

        // Lever holds output high through and after a button pulse
        hi0 = 0;
        send(5'd0, 2'b01);
        send(5'd0, 2'b11);
        tick_n(12, 1'b0, '0);
        chk("lever_btn_high_ticks", hi0, 12);
        chk("lever_btn_out", out[0], 1);
        chk("lever_btn_busy", busy[0], 0);
        send(5'd0, 2'b00);
        tick_n(1, 1'b0, '0);

        // Command held across a tick cycle
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 5'd7;
        cmd_if.cmd_op    = 2'b01;
        tick             = 1'b1;
        e = model_tick();
        #1 chk("ready_tick", cmd_if.cmd_ready, 0);
        @(negedge clk);
        chk("hold_tick_out", out, e.o);
        last_out = e.o;
        tick = 1'b0;
        #1 chk("ready_after_tick", cmd_if.cmd_ready, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        model_cmd(5'd7, 2'b01);
        chk("hold_err", err, 0);
        chk("hold_not_yet", out, last_out);
        tick_n(1, 1'b0, '0);
        chk("hold_applied", out, 16'h0080);

        // Out-of-range channel
        send(5'd20, 2'b01);
        tick_n(1, 1'b0, '0);
        chk("oor_out", out, 16'h0080);

        // Reset mid-countdown with levers set
        send(5'd2, 2'b11);
        send(5'd0, 2'b01);
        tick_n(2, 1'b0, '0);
        chk("pre_rst_out", out, 16'h0085);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_if.cmd_ready, 0);
        model_reset();
        sbq.delete();
        last_out = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(1, 1'b0, '0);
        chk("post_rst_out", out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_injector.md
Name: input_injector

Overview:
- Host-side stimulus source feeding the redstone component network: per-channel levers and buttons driving repeater/torch/comparator `i_in` nets.
- Host commands arrive on a valid/ready port at any time and are staged. They are applied only at a simulation tick boundary (`i_tick` strobe), so component inputs change in lock-step with the component tick.
- Button channels produce a timed pulse measured in ticks, matching game button behaviour.

Parameters:
- CHANNELS, 16, number of independent input channels (1..256).
- BUTTON_TICKS, 10, ticks a button output stays high after a press (>=1).
- CH_W, $clog2(CHANNELS) (min 1), width of channel index.

Ports:
- i_clk  in  1  system clock; all logic rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle strobe marking a simulation tick; staged state commits on this cycle.
- i_cmd_valid  in  1  host command valid.
- o_cmd_ready  out  1  block can accept a command this cycle.
- i_cmd_ch  in  CH_W  target channel.
- i_cmd_op  in  2  00 lever off, 01 lever on, 10 lever toggle, 11 button press.
- o_out  out  CHANNELS  registered drive to component inputs; bit n = lever[n] | button_active[n].
- o_btn_busy  out  CHANNELS  bit n high while channel n button countdown is nonzero.
- o_err  out  1  one-cycle pulse: accepted command had channel >= CHANNELS.

Behaviour:
- Reset (async assert, sync-release use only): o_out=0, o_btn_busy=0, o_err=0, all lever, staged-lever, press-pending and countdown registers 0. o_cmd_ready=0 while reset is asserted.
- Handshake:
  - o_cmd_ready = !i_tick (combinational from i_tick, reset-gated).
  - Command accepted when i_cmd_valid & o_cmd_ready; at most one per cycle.
  - Commands presented during a tick cycle are not accepted; the host holds them.
- Staging (non-tick cycles):
  - Staged lever copy lev_s[ch] updated by op: 00 -> 0, 01 -> 1, 10 -> ~lev_s[ch]. Toggle applies to the staged value, so multiple ops on one channel between ticks compose sequentially.
  - op 11 sets press_pend[ch].
  - Out-of-range channel: no state change, o_err=1 next cycle.
- Tick commit (cycle with i_tick=1), all registers updated on that edge:
  - lever[n] <= lev_s[n].
  - If press_pend[n] and cnt[n]==0: cnt[n] <= BUTTON_TICKS.
  - Else if cnt[n]!=0: cnt[n] <= cnt[n]-1. A press while active is ignored and does not restart the countdown.
  - press_pend[n] <= 0.
  - o_out[n] <= lev_s[n] | (next cnt[n] != 0).
- Latency: a command accepted before tick k is visible on o_out the cycle after tick k's edge. A button is high for exactly BUTTON_TICKS ticks, then falls on the commit of tick k+BUTTON_TICKS.
- o_out and o_btn_busy change only on tick-commit edges; they are stable between ticks.
- Counter width: $clog2(BUTTON_TICKS+1); it must never underflow or wrap.
- Reset mid-countdown: all counts and pending state cleared immediately; o_out drops to 0 asynchronously.
- Back-to-back ticks (i_tick high on consecutive cycles) are legal: each commits and decrements; no commands are accepted during them.

Test Plan:
- Reset release, CHANNELS=16, cmd ch3 op01, then tick -> o_out=0x0008 after the tick edge; o_out=0 before the tick.
- ch5 op01, ch5 op10, ch5 op10 before one tick -> o_out[5]=1; add another op10 before the next tick -> o_out[5]=0.
- BUTTON_TICKS=10, ch0 op11, then 12 ticks -> o_out[0] high after ticks 1..10, low after tick 11; o_btn_busy[0] tracks it.
- Re-press ch0 after tick 4 of a countdown -> output still falls after tick 10, not extended. Lever on same channel plus an ended button -> o_out[0] stays 1.
- i_cmd_valid held across an i_tick cycle -> o_cmd_ready=0 that cycle; command accepted the next cycle and applied at the following tick. Channel 20 with CHANNELS=16 -> o_err pulses once, o_out unchanged.
- Assert i_rst_n=0 mid-countdown with levers set -> o_out=0 immediately; after release and one tick with no commands, o_out remains 0.
